// File: rtl/core_pkg.sv
// Shared hazard-control types: FSM encoding, forward-select codes, stage control bundle.
package core_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_PS = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_REGFILE = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_MEM     = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_WB      = FWD_W'(2);

  // ps_en/ps_clear bit 0 is stage register 1
  typedef struct packed {
    logic              pc_en;
    logic [NUM_PS-1:0] ps_en;
    logic [NUM_PS-1:0] ps_clear;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en:    1'b1,
    ps_en:    {NUM_PS{1'b1}},
    ps_clear: {NUM_PS{1'b1}}
  };

  // Register 0 is hard-wired, so it never creates a dependency
  function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; slave modport is the controller side.
interface hazard_ctrl_if;
  import core_pkg::*;

  logic [REG_W-1:0] id_rs_req;
  logic [REG_W-1:0] id_rt_req;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] ex_rs_req;
  logic [REG_W-1:0] ex_rt_req;
  logic             ex_regfile_w_en;
  logic [REG_W-1:0] ex_regfile_req_w;
  logic             ex_r_datamem;
  logic             mem_regfile_w_en;
  logic [REG_W-1:0] mem_regfile_req_w;
  logic             wb_regfile_w_en;
  logic [REG_W-1:0] wb_regfile_req_w;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt;

  logic             pc_en;
  logic             ps1_en, ps2_en, ps3_en, ps4_en;
  logic             ps1_clear, ps2_clear, ps3_clear, ps4_clear;
  logic [FWD_W-1:0] fwd_rs_sel;
  logic [FWD_W-1:0] fwd_rt_sel;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs_req, id_rt_req, id_rs_used, id_rt_used, ex_rs_req, ex_rt_req,
           ex_regfile_w_en, ex_regfile_req_w, ex_r_datamem,
           mem_regfile_w_en, mem_regfile_req_w, wb_regfile_w_en, wb_regfile_req_w,
           branch_taken, mem_busy, halt,
    input  pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
           ps1_clear, ps2_clear, ps3_clear, ps4_clear,
           fwd_rs_sel, fwd_rt_sel, halted, stall_count, flush_count
  );

  modport slave (
    input  id_rs_req, id_rt_req, id_rs_used, id_rt_used, ex_rs_req, ex_rt_req,
           ex_regfile_w_en, ex_regfile_req_w, ex_r_datamem,
           mem_regfile_w_en, mem_regfile_req_w, wb_regfile_w_en, wb_regfile_req_w,
           branch_taken, mem_busy, halt,
    output pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
           ps1_clear, ps2_clear, ps3_clear, ps4_clear,
           fwd_rs_sel, fwd_rt_sel, halted, stall_count, flush_count
  );

endinterface

// File: rtl/fwd_unit.sv
// One EX operand's forwarding source select; MEM result is newer than WB so it wins.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] src_req,
  input  logic             mem_w_en,
  input  logic [REG_W-1:0] mem_req_w,
  input  logic             wb_w_en,
  input  logic [REG_W-1:0] wb_req_w,
  output logic [FWD_W-1:0] sel_c
);

  always_comb begin
    sel_c = FWD_REGFILE;
    if (mem_w_en && reg_match(mem_req_w, src_req)) begin
      sel_c = FWD_MEM;
    end else if (wb_w_en && reg_match(wb_req_w, src_req)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory-wait freeze, halt and operand forwarding.
// Define HAZARD_STAT_EN to build the saturating stall/flush statistics counters.
module hazard_ctrl
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  state_e      state, next_state;
  stage_ctrl_t ctrl;
  logic        load_use;

  assign load_use = hz.ex_r_datamem && hz.ex_regfile_w_en &&
                    ((hz.id_rs_used && reg_match(hz.ex_regfile_req_w, hz.id_rs_req)) ||
                     (hz.id_rt_used && reg_match(hz.ex_regfile_req_w, hz.id_rt_req)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  // RUN and MEM_WAIT share one priority chain: a released MEM_WAIT behaves as RUN at once
  always_comb begin
    next_state = state;
    ctrl       = CTRL_RUN;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (hz.halt) begin
          ctrl.pc_en = 1'b0;
          ctrl.ps_en = '0;
          next_state = ST_HALTED;
        end else if (hz.mem_busy) begin
          ctrl.pc_en = 1'b0;
          ctrl.ps_en = '0;
          next_state = ST_MEM_WAIT;
        end else begin
          next_state = ST_RUN;
          if (hz.branch_taken) begin
            ctrl.ps_clear[1:0] = 2'b00;
          end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ps_en[0]    = 1'b0;
            ctrl.ps_clear[1] = 1'b0;
          end
        end
      end
      ST_HALTED: begin
        ctrl.pc_en = 1'b0;
        ctrl.ps_en = '0;
      end
      default: next_state = ST_RUN;
    endcase
  end

  assign hz.pc_en     = ctrl.pc_en;
  assign hz.ps1_en    = ctrl.ps_en[0];
  assign hz.ps2_en    = ctrl.ps_en[1];
  assign hz.ps3_en    = ctrl.ps_en[2];
  assign hz.ps4_en    = ctrl.ps_en[3];
  assign hz.ps1_clear = ctrl.ps_clear[0];
  assign hz.ps2_clear = ctrl.ps_clear[1];
  assign hz.ps3_clear = ctrl.ps_clear[2];
  assign hz.ps4_clear = ctrl.ps_clear[3];
  assign hz.halted    = (state == ST_HALTED);

  fwd_unit u_fwd_rs (
    .src_req   (hz.ex_rs_req),
    .mem_w_en  (hz.mem_regfile_w_en),
    .mem_req_w (hz.mem_regfile_req_w),
    .wb_w_en   (hz.wb_regfile_w_en),
    .wb_req_w  (hz.wb_regfile_req_w),
    .sel_c     (hz.fwd_rs_sel)
  );

  fwd_unit u_fwd_rt (
    .src_req   (hz.ex_rt_req),
    .mem_w_en  (hz.mem_regfile_w_en),
    .mem_req_w (hz.mem_regfile_req_w),
    .wb_w_en   (hz.wb_regfile_w_en),
    .wb_req_w  (hz.wb_regfile_req_w),
    .sel_c     (hz.fwd_rt_sel)
  );

`ifdef HAZARD_STAT_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Count only the hazard that actually took effect under the priority chain
  assign stall_inc = (state != ST_HALTED) && !hz.halt &&
                     (hz.mem_busy || (!hz.branch_taken && load_use));
  assign flush_inc = (state != ST_HALTED) && !hz.halt && !hz.mem_busy && hz.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
`else
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif

endmodule
